// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed-bus controller: runs one register write/read per request with timed strobes.
// Build option RTC_CMD_LATCH_EN adds a one-deep pending request chained directly after GAP.
module rtc_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       escribe,
  output logic       lee,
  output logic       rtc_cs_n,
  output logic       rtc_ad_n,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_STB = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_STB = 3'd5,
    D_HLD = 3'd6,
    GAP   = 3'd7
  } state_e;

  localparam logic [7:0] SETUP_C = 8'(T_SETUP);
  localparam logic [7:0] PULSE_C = 8'(T_PULSE);
  localparam logic [7:0] HOLD_C  = 8'(T_HOLD);
  localparam logic [7:0] GAP_C   = 8'(T_GAP);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_q, wr_d;

  logic [7:0] rdata_q, rdata_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       done_q, done_d;
  logic       esc_q, esc_d;
  logic       lee_q, lee_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_n_q, ad_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       ad_oe_q, ad_oe_d;

  logic       req_any_s;
  logic       accept_ok_s;
  logic       last_s;
  logic       take_pend_s;
  logic       a_ph_s;
  logic       d_ph_s;
  logic [7:0] start_addr_s;
  logic [7:0] start_wdata_s;
  logic       start_wr_s;

  logic       pend_v_q;
  logic [7:0] pend_addr_q;
  logic [7:0] pend_wdata_q;
  logic       pend_wr_q;

  assign req_any_s = req_wr | req_rd;
  // Outputs lag the state by one cycle, so wait until the busy flags have dropped too.
  assign accept_ok_s = (state_q == IDLE) && !esc_q && !lee_q;
  assign last_s      = (cnt_q == 8'd1);
  assign a_ph_s      = (state_q == A_SET) || (state_q == A_STB) || (state_q == A_HLD);
  assign d_ph_s      = (state_q == D_SET) || (state_q == D_STB) || (state_q == D_HLD);

  assign start_addr_s  = pend_v_q ? pend_addr_q  : addr;
  assign start_wdata_s = pend_v_q ? pend_wdata_q : wdata;
  assign start_wr_s    = pend_v_q ? pend_wr_q    : req_wr;

`ifdef RTC_CMD_LATCH_EN
  logic       pend_v_d;
  logic [7:0] pend_addr_d;
  logic [7:0] pend_wdata_d;
  logic       pend_wr_d;

  // Pending slot: filled by a request that cannot start now, freed when it launches.
  always_comb begin
    pend_v_d     = pend_v_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    pend_wr_d    = pend_wr_q;
    if (take_pend_s) begin
      pend_v_d = 1'b0;
    end else if (req_any_s && !accept_ok_s && !pend_v_q) begin
      pend_v_d     = 1'b1;
      pend_addr_d  = addr;
      pend_wdata_d = wdata;
      pend_wr_d    = req_wr;
    end else begin
      pend_v_d = pend_v_q;
    end
  end

  // Pending slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q     <= 1'b0;
      pend_addr_q  <= 8'd0;
      pend_wdata_q <= 8'd0;
      pend_wr_q    <= 1'b0;
    end else begin
      pend_v_q     <= pend_v_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_wr_q    <= pend_wr_d;
    end
  end
`else
  assign pend_v_q     = 1'b0;
  assign pend_addr_q  = 8'd0;
  assign pend_wdata_q = 8'd0;
  assign pend_wr_q    = 1'b0;
`endif

  // Next state, phase counter and latched command.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != 8'd0) ? (cnt_q - 8'd1) : 8'd0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    take_pend_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (accept_ok_s && (pend_v_q || req_any_s)) begin
          state_d     = A_SET;
          cnt_d       = SETUP_C;
          addr_d      = start_addr_s;
          wdata_d     = start_wdata_s;
          wr_d        = start_wr_s;
          take_pend_s = pend_v_q;
        end else begin
          state_d = IDLE;
        end
      end
      A_SET: begin
        if (last_s) begin
          state_d = A_STB;
          cnt_d   = PULSE_C;
        end else begin
          state_d = A_SET;
        end
      end
      A_STB: begin
        if (last_s) begin
          state_d = A_HLD;
          cnt_d   = HOLD_C;
        end else begin
          state_d = A_STB;
        end
      end
      A_HLD: begin
        if (last_s) begin
          state_d = D_SET;
          cnt_d   = SETUP_C;
        end else begin
          state_d = A_HLD;
        end
      end
      D_SET: begin
        if (last_s) begin
          state_d = D_STB;
          cnt_d   = PULSE_C;
        end else begin
          state_d = D_SET;
        end
      end
      D_STB: begin
        if (last_s) begin
          state_d = D_HLD;
          cnt_d   = HOLD_C;
        end else begin
          state_d = D_STB;
        end
      end
      D_HLD: begin
        if (last_s) begin
          state_d = GAP;
          cnt_d   = GAP_C;
        end else begin
          state_d = D_HLD;
        end
      end
      GAP: begin
        if (last_s && pend_v_q) begin
          state_d     = A_SET;
          cnt_d       = SETUP_C;
          addr_d      = pend_addr_q;
          wdata_d     = pend_wdata_q;
          wr_d        = pend_wr_q;
          take_pend_s = 1'b1;
        end else if (last_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Bus pins and status flags, decoded from the current state and registered.
  always_comb begin
    cs_n_d  = ~(a_ph_s | d_ph_s);
    ad_n_d  = ~a_ph_s;
    wr_n_d  = ~((state_q == A_STB) || ((state_q == D_STB) && wr_q));
    rd_n_d  = ~((state_q == D_STB) && !wr_q);
    ad_oe_d = a_ph_s | (d_ph_s & wr_q);
    esc_d   = (state_q != IDLE) && wr_q;
    lee_d   = (state_q != IDLE) && !wr_q;
    done_d  = (state_q == GAP) && (cnt_q == GAP_C);
    if (a_ph_s) begin
      ad_out_d = addr_q;
    end else if (d_ph_s && wr_q) begin
      ad_out_d = wdata_q;
    end else begin
      ad_out_d = 8'd0;
    end
    // First D_HLD state cycle is when the registered rd_n still shows the last strobe cycle.
    if ((state_q == D_HLD) && (cnt_q == HOLD_C) && !wr_q) begin
      rdata_d = ad_in;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, counter, command and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      wr_q     <= 1'b0;
      rdata_q  <= 8'd0;
      ad_out_q <= 8'd0;
      done_q   <= 1'b0;
      esc_q    <= 1'b0;
      lee_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      ad_out_q <= ad_out_d;
      done_q   <= done_d;
      esc_q    <= esc_d;
      lee_q    <= lee_d;
      cs_n_q   <= cs_n_d;
      ad_n_q   <= ad_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  assign rdata    = rdata_q;
  assign done     = done_q;
  assign escribe  = esc_q;
  assign lee      = lee_q;
  assign rtc_cs_n = cs_n_q;
  assign rtc_ad_n = ad_n_q;
  assign rtc_wr_n = wr_n_q;
  assign rtc_rd_n = rd_n_q;
  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: default-timing and all-ones-timing instances
// compared cycle by cycle against a phase-window model of the bus transfer.
module tb_rtc_bus_ctrl;

  logic       clk;
  logic       reset;
  logic       req_wr, req_rd;
  logic [7:0] addr, wdata;
  logic [7:0] bus_val;
  bit         sel_fast;

  logic [7:0] d_rdata, d_ad_out, d_ad_in;
  logic       d_done, d_esc, d_lee, d_cs_n, d_ad_n, d_wr_n, d_rd_n, d_ad_oe;
  logic [7:0] f_rdata, f_ad_out, f_ad_in;
  logic       f_done, f_esc, f_lee, f_cs_n, f_ad_n, f_wr_n, f_rd_n, f_ad_oe;
  logic       d_req_wr, d_req_rd, f_req_wr, f_req_rd;

  logic [7:0] obs_ctl, obs_ad, obs_rdata;
  logic [7:0] ref_rdata [2];

  int vectors;
  int miscompares;

  assign d_req_wr = req_wr & ~sel_fast;
  assign d_req_rd = req_rd & ~sel_fast;
  assign f_req_wr = req_wr & sel_fast;
  assign f_req_rd = req_rd & sel_fast;
  // The RTC only drives the expected value while it sees RD_n low.
  assign d_ad_in = d_rd_n ? ~bus_val : bus_val;
  assign f_ad_in = f_rd_n ? ~bus_val : bus_val;

  rtc_bus_ctrl #(.T_SETUP(2), .T_PULSE(4), .T_HOLD(2), .T_GAP(4)) dut (
    .clk(clk), .reset(reset), .req_wr(d_req_wr), .req_rd(d_req_rd),
    .addr(addr), .wdata(wdata), .rdata(d_rdata), .done(d_done),
    .escribe(d_esc), .lee(d_lee), .rtc_cs_n(d_cs_n), .rtc_ad_n(d_ad_n),
    .rtc_wr_n(d_wr_n), .rtc_rd_n(d_rd_n), .ad_out(d_ad_out), .ad_oe(d_ad_oe),
    .ad_in(d_ad_in)
  );

  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .req_wr(f_req_wr), .req_rd(f_req_rd),
    .addr(addr), .wdata(wdata), .rdata(f_rdata), .done(f_done),
    .escribe(f_esc), .lee(f_lee), .rtc_cs_n(f_cs_n), .rtc_ad_n(f_ad_n),
    .rtc_wr_n(f_wr_n), .rtc_rd_n(f_rd_n), .ad_out(f_ad_out), .ad_oe(f_ad_oe),
    .ad_in(f_ad_in)
  );

  always_comb begin
    obs_ctl   = sel_fast ? {f_cs_n, f_ad_n, f_wr_n, f_rd_n, f_ad_oe, f_done, f_esc, f_lee}
                         : {d_cs_n, d_ad_n, d_wr_n, d_rd_n, d_ad_oe, d_done, d_esc, d_lee};
    obs_ad    = sel_fast ? f_ad_out : d_ad_out;
    obs_rdata = sel_fast ? f_rdata : d_rdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {cs_n, ad_n, wr_n, rd_n, ad_oe, done, escribe, lee} for cycle k after acceptance.
  function automatic logic [7:0] model_ctl(input int k, input bit dw,
                                           input int s, input int p, input int h, input int g);
    int x, l, j;
    bit aph, dph, stb, busy, dn;
    x    = s + p + h;
    l    = 2 * x + g;
    aph  = (k >= 1) && (k <= x);
    dph  = (k > x) && (k <= 2 * x);
    j    = aph ? k : k - x;
    stb  = (aph || dph) && (j > s) && (j <= s + p);
    busy = (k >= 1) && (k <= l);
    dn   = (k == 2 * x + 1);
    return {~(aph | dph), ~aph, ~(stb && (aph || dw)), ~(stb && dph && !dw),
            aph | (dph && dw), dn, busy && dw, busy && !dw};
  endfunction

  task automatic run_xfer(input bit w, input bit r, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] rv, input bit fast, input string tag);
    int s, p, h, g, x, l, fi;
    logic [7:0] e, want;
    s = fast ? 1 : 2;  p = fast ? 1 : 4;  h = fast ? 1 : 2;  g = fast ? 1 : 4;
    x = s + p + h;
    l = 2 * x + g;
    fi = fast ? 1 : 0;
    sel_fast = fast;
    bus_val  = rv;
    req_wr = w; req_rd = r; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_wr = 1'b0; req_rd = 1'b0; addr = 8'($urandom); wdata = 8'($urandom);
    for (int k = 0; k <= l + 1; k++) begin
      e = model_ctl(k, w, s, p, h, g);
      vectors++;
      if (obs_ctl !== e) begin
        miscompares++;
        $display("FAIL %s ctl k=%0d got %b want %b", tag, k, obs_ctl, e);
      end
      if (e[3]) begin
        want = (k <= x) ? a : wd;
        vectors++;
        if (obs_ad !== want) begin
          miscompares++;
          $display("FAIL %s ad_out k=%0d got %h want %h", tag, k, obs_ad, want);
        end
      end
      if (!w && k > 2 * x) begin
        vectors++;
        if (obs_rdata !== rv) begin
          miscompares++;
          $display("FAIL %s rdata k=%0d got %h want %h", tag, k, obs_rdata, rv);
        end
      end else if (w || k <= x) begin
        vectors++;
        if (obs_rdata !== ref_rdata[fi]) begin
          miscompares++;
          $display("FAIL %s rdata_hold k=%0d got %h want %h", tag, k, obs_rdata, ref_rdata[fi]);
        end
      end
      @(posedge clk); #1;
    end
    if (!w) ref_rdata[fi] = rv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if ({d_cs_n, d_ad_n, d_wr_n, d_rd_n, d_ad_oe, d_done, d_esc, d_lee} !== 8'hF0) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want %b", {d_cs_n, d_ad_n, d_wr_n, d_rd_n, d_ad_oe, d_done, d_esc, d_lee}, 8'hF0);
    end
    if (d_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rdata got %h want 00", d_rdata);
    end
    if (d_ad_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ad_out got %h want 00", d_ad_out);
    end
    if ({f_cs_n, f_ad_n, f_wr_n, f_rd_n, f_ad_oe, f_done, f_esc, f_lee} !== 8'hF0) begin
      miscompares++;
      $display("FAIL reset_fast_ctl got %b want %b", {f_cs_n, f_ad_n, f_wr_n, f_rd_n, f_ad_oe, f_done, f_esc, f_lee}, 8'hF0);
    end
    ref_rdata[0] = 8'h00;
    ref_rdata[1] = 8'h00;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_xfer(1'b1, 1'b0, 8'h02, 8'h08, 8'hC3, 1'b0, "write");
  endtask

  task automatic test_read();
    run_xfer(1'b0, 1'b1, 8'h21, 8'h77, 8'h59, 1'b0, "read");
  endtask

  task automatic test_both();
    run_xfer(1'b1, 1'b1, 8'h3C, 8'hA5, 8'h11, 1'b0, "both");
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    sel_fast = 1'b0;
    bus_val  = 8'h00;
    req_wr = 1'b1; addr = 8'h44; wdata = 8'h99;
    @(posedge clk); #1;
    req_wr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
    end
    e = model_ctl(12, 1'b1, 2, 4, 2, 4);
    vectors++;
    if (obs_ctl !== e) begin
      miscompares++;
      $display("FAIL reset_mid_pre got %b want %b", obs_ctl, e);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors += 2;
    if (obs_ctl !== 8'hF0) begin
      miscompares++;
      $display("FAIL reset_mid_ctl got %b want %b", obs_ctl, 8'hF0);
    end
    if (obs_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_rdata got %h want 00", obs_rdata);
    end
    ref_rdata[0] = 8'h00;
    ref_rdata[1] = 8'h00;
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs_ctl !== 8'hF0) begin
        miscompares++;
        $display("FAIL reset_mid_idle k=%0d got %b want %b", k, obs_ctl, 8'hF0);
      end
    end
    run_xfer(1'b1, 1'b0, 8'h45, 8'h9A, 8'h00, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int x, l;
    logic [7:0] e, want, want_rd;
    logic [7:0] a1, w1, a2, rv2;
    x = 8;
    l = 20;
    a1 = 8'h0B; w1 = 8'h5E; a2 = 8'h2D; rv2 = 8'hE7;
    sel_fast = 1'b0;
    bus_val  = rv2;
    req_wr = 1'b1; req_rd = 1'b0; addr = a1; wdata = w1;
    @(posedge clk); #1;
    req_wr = 1'b0;
    for (int k = 0; k <= 2 * l + 1; k++) begin
`ifdef RTC_CMD_LATCH_EN
      if (k <= l) begin
        e = model_ctl(k, 1'b1, 2, 4, 2, 4);
        want = (k <= x) ? a1 : w1;
      end else begin
        e = model_ctl(k - l, 1'b0, 2, 4, 2, 4);
        want = a2;
      end
`else
      e = model_ctl(k, 1'b1, 2, 4, 2, 4);
      want = (k <= x) ? a1 : w1;
`endif
      vectors++;
      if (obs_ctl !== e) begin
        miscompares++;
        $display("FAIL b2b ctl k=%0d got %b want %b", k, obs_ctl, e);
      end
      if (e[3]) begin
        vectors++;
        if (obs_ad !== want) begin
          miscompares++;
          $display("FAIL b2b ad_out k=%0d got %h want %h", k, obs_ad, want);
        end
      end
      req_rd = (k == 5);
      req_wr = (k == 7);
      addr   = (k == 5) ? a2 : 8'h6F;
      wdata  = 8'h3B;
      @(posedge clk); #1;
    end
`ifdef RTC_CMD_LATCH_EN
    want_rd = rv2;
`else
    want_rd = ref_rdata[0];
`endif
    vectors++;
    if (obs_rdata !== want_rd) begin
      miscompares++;
      $display("FAIL b2b rdata got %h want %h", obs_rdata, want_rd);
    end
    ref_rdata[0] = want_rd;
  endtask

  task automatic test_fast();
    run_xfer(1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1, "fast_write");
    run_xfer(1'b0, 1'b1, 8'h78, 8'h9A, 8'hBC, 1'b1, "fast_read");
  endtask

  task automatic test_random();
    bit w, r, f;
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      f = 1'($urandom_range(0, 1));
      run_xfer(w, r, 8'($urandom), 8'($urandom), 8'($urandom), f, "random");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    req_wr = 1'b0; req_rd = 1'b0; addr = 8'h00; wdata = 8'h00;
    bus_val = 8'h00;
    sel_fast = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_reset_mid();
    test_back_to_back();
    test_fast();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
